// File: rtl/logip_pkg.sv
// Shared types for the logic-analyzer capture path: controller states and
// the width of the read/delay count configuration.
package logip_pkg;

    localparam int CW = 16;

    typedef logic [CW-1:0] cnt_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        DELAY = 3'd2,
        READ  = 3'd3,
        SEND  = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/capture_ctrl.sv
// Capture sequencer: fills a circular sample memory until a trigger plus a
// post-trigger delay, then reads the requested samples back newest first.
module capture_ctrl
    import logip_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = logip_pkg::CW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cmd_run_i,
    input  logic          cmd_reset_i,
    input  logic [CW-1:0] cfg_read_cnt_i,
    input  logic [CW-1:0] cfg_delay_cnt_i,
    input  logic          smpl_valid_i,
    input  logic          trg_i,
    output logic          mem_we_o,
    output logic          mem_re_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          tx_valid_o,
    input  logic          tx_ready_i,
    output logic          armed_o,
    output logic          triggered_o,
    output logic          busy_o
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    ctrl_state_t   state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] delay_q, delay_d;
    logic [CW-1:0] read_q, read_d;
    logic          trig_q, trig_d;

    // More samples than the memory holds would only resend the same entries.
    function automatic logic [CW-1:0] clamp_read(input logic [CW-1:0] cnt);
        return (cnt > DEPTH_C) ? DEPTH_C : cnt;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            delay_q  <= '0;
            read_q   <= '0;
            trig_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            delay_q  <= delay_d;
            read_q   <= read_d;
            trig_q   <= trig_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        delay_d  = delay_q;
        read_d   = read_q;
        trig_d   = trig_q;

        if (cmd_reset_i) begin
            state_d = IDLE;
            trig_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_run_i) begin
                        delay_d  = cfg_delay_cnt_i;
                        read_d   = clamp_read(cfg_read_cnt_i);
                        wr_ptr_d = '0;
                        state_d  = ARMED;
                    end
                end
                ARMED: begin
                    if (smpl_valid_i) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (trg_i) begin
                            trig_d = 1'b1;
                            if (delay_q == '0) begin
                                rd_ptr_d = wr_ptr_q;
                                state_d  = READ;
                            end else begin
                                state_d = DELAY;
                            end
                        end
                    end
                end
                DELAY: begin
                    // Delay is never zero on entry, so reaching one marks the last sample.
                    if (smpl_valid_i) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        delay_d  = delay_q - 1'b1;
                        if (delay_q <= CW'(1)) begin
                            rd_ptr_d = wr_ptr_q;
                            state_d  = READ;
                        end
                    end
                end
                READ: begin
                    if (read_q == '0) begin
                        trig_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (tx_ready_i) begin
                        rd_ptr_d = rd_ptr_q - 1'b1;
                        read_d   = read_q - 1'b1;
                        state_d  = READ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Write and read enables are gated by the abort pulse so no access completes.
    always_comb begin
        mem_we_o    = smpl_valid_i && (state_q == ARMED || state_q == DELAY) && !cmd_reset_i;
        mem_re_o    = (state_q == READ) && (read_q != '0) && !cmd_reset_i;
        mem_addr_o  = (state_q == ARMED || state_q == DELAY) ? wr_ptr_q : rd_ptr_q;
        tx_valid_o  = (state_q == SEND);
        armed_o     = (state_q == ARMED);
        triggered_o = trig_q;
        busy_o      = (state_q != IDLE);
    end

endmodule
